rider_steer_seq: RTL and testbench
==================================

// Module: rider_steer_seq
// PURPOSE
//  Rider-presence / steering-enable sequencer for the balance controller.
//  Watches the left/right load-cell readings and produces rider_off and
//  en_steer, which gate the PID integrator and SegwayMath steering.
//  Steering is enabled only after the rider stands balanced for a settle time.
//  Steering is dropped when the rider leans off one side or steps off.
// PARAMETERS
//  fast_sim      1       1: settle timer 15 bits (sim); 0: 26 bits (~1.34 s @ 50 MHz)
//  MIN_RIDER_WT  12'h200 nominal rider-present weight (sum of both cells)
//  WT_HYST       8'h40   hysteresis about MIN_RIDER_WT
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  vld        in   1   new load-cell sample valid (single-cycle strobe)
//  lft_ld     in   12  left load cell, unsigned
//  rght_ld    in   12  right load cell, unsigned
//  pwr_up     in   1   system powered (from authentication block)
//  en_steer   out  1   steering enabled to SegwayMath
//  rider_off  out  1   no rider; clears PID integrator
//  seq_state  out  2   debug: 00 IDLE, 01 WAIT, 10 STEER
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, settle timer=0, en_steer=0, rider_off=1.
//  - Outputs are Moore, decoded from the state flop:
//    - en_steer = (STEER).
//    - rider_off = (IDLE).
//  - Arithmetic:
//    - sum = lft_ld + rght_ld (13 b unsigned).
//    - diff = |lft_ld - rght_ld| (12 b).
//    - on_thr = MIN_RIDER_WT + WT_HYST; off_thr = MIN_RIDER_WT - WT_HYST (13 b).
//    - sum_gt_min = sum > on_thr; sum_lt_min = sum < off_thr.
//    - diff_gt_1_4 = diff > (sum>>2); diff_gt_15_16 = diff > (sum - (sum>>4)).
//  - Settle timer (TMR_W = fast_sim ? 15 : 26):
//    - counts +1 every clk while state=WAIT;
//    - saturates at all-ones; tmr_full = &tmr;
//    - cleared on every entry to WAIT and whenever diff_gt_1_4 is seen in WAIT;
//    - held at 0 in IDLE and STEER.
//  - pwr_up=0 forces state=IDLE on the next clk edge, independent of vld;
//    highest priority.
//  - All other transitions are evaluated only on cycles with vld=1, in priority
//    order:
//    - IDLE: sum_gt_min -> WAIT (timer cleared).
//    - WAIT:
//      - sum_lt_min -> IDLE;
//      - else diff_gt_1_4 -> stay, clear timer;
//      - else tmr_full -> STEER.
//    - STEER:
//      - sum_lt_min -> IDLE;
//      - else diff_gt_15_16 -> WAIT (timer cleared).
//  - Latency: state changes one clk after the qualifying vld edge; outputs
//    follow in the same cycle as the state.
//  - Boundaries:
//    - sum exactly equal to on_thr or off_thr causes no transition (strict
//      compares).
//    - Simultaneous tmr_full and diff_gt_1_4 on a vld: clear the timer and
//      stay in WAIT.
//    - Timer reaching full between vlds: wait for the next vld, then enter STEER.
//    - Illegal state 11: go to IDLE next clk.
//    - rst mid-WAIT or mid-STEER returns to the reset values immediately
//      (async), without waiting for a clock edge.
// TESTING  (fast_sim=1, defaults: on_thr=0x240, off_thr=0x1C0; vld every 16 clk)
//  1. rst pulse mid-STEER -> en_steer=0, rider_off=1, seq_state=00 before
//     the next clk edge.
//  2. pwr_up=1, lft=rght=0x150 (sum 0x2A0, diff 0) ->
//     - WAIT after the first vld;
//     - STEER (en_steer=1, rider_off=0) on the first vld after 2^15-1 clks
//       in WAIT.
//  3. In WAIT, lft=0x200, rght=0x080 (diff 0x180 > 0xA0) -> timer cleared on
//     every vld; en_steer never asserts over 2^16 clks.
//  4. In STEER, lft=0x2A0, rght=0x000 (diff 0x2A0 > 0x276) -> WAIT next clk,
//     en_steer=0, rider_off=0.
//  5. In STEER, lft=rght=0x100 (sum 0x200) -> stays in STEER.
//     Then lft=rght=0x0D0 (sum 0x1A0) -> IDLE, rider_off=1.
//  6. pwr_up drops in STEER with vld=0 -> IDLE next clk.
//     Then lft=0x120, rght=0x120 (sum=0x240 = on_thr) with pwr_up=1 -> stays
//     in IDLE.

Source files
------------

// File: rtl/rider_steer_seq.sv
// -----------------------------------------------------------------------------
// rider_steer_seq
//
// Rider-presence / steering-enable sequencer for the balance controller.
// Watches the left/right load-cell readings and decides whether a rider is on
// the platform (rider_off) and whether steering may be handed to SegwayMath
// (en_steer). Steering is enabled only after the rider has stood balanced for
// a full settle time. It is dropped when the rider leans off one side or steps
// off the platform.
//
// Parameters
//   fast_sim      1: 15-bit settle timer (simulation); 0: 26-bit (~1.34 s @ 50 MHz)
//   MIN_RIDER_WT  nominal rider-present weight (sum of both cells)
//   WT_HYST       hysteresis applied either side of MIN_RIDER_WT
//
// Ports
//   clk        in   1   system clock
//   rst        in   1   asynchronous, active-high reset
//   vld        in   1   new load-cell sample valid (single-cycle strobe)
//   lft_ld     in   12  left load cell, unsigned
//   rght_ld    in   12  right load cell, unsigned
//   pwr_up     in   1   system powered (from authentication block)
//   en_steer   out  1   steering enabled to SegwayMath
//   rider_off  out  1   no rider; clears the PID integrator
//   seq_state  out  2   debug view of the state: 00 IDLE, 01 WAIT, 10 STEER
// -----------------------------------------------------------------------------
module rider_steer_seq #(
  parameter bit          fast_sim     = 1'b1,
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [7:0]  WT_HYST      = 8'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic        pwr_up,
  output logic        en_steer,
  output logic        rider_off,
  output logic [1:0]  seq_state
);

  localparam int TMR_W = fast_sim ? 15 : 26;

  // Thresholds are held at 13 bits so they compare directly against the sum.
  localparam logic [12:0] ON_THR  = {1'b0, MIN_RIDER_WT} + {5'b0_0000, WT_HYST};
  localparam logic [12:0] OFF_THR = {1'b0, MIN_RIDER_WT} - {5'b0_0000, WT_HYST};

  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_STEER = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [TMR_W-1:0]  tmr_r;
  logic [TMR_W-1:0]  tmr_nxt_s;
  logic              tmr_clr_s;
  logic              tmr_full_s;
  logic              en_steer_r;
  logic              rider_off_r;

  logic [12:0]       sum_s;
  logic [11:0]       diff_s;
  logic [12:0]       sum_q_s;       // sum / 4
  logic [12:0]       sum_15_16_s;   // sum - sum / 16
  logic              sum_gt_min_s;
  logic              sum_lt_min_s;
  logic              diff_gt_1_4_s;
  logic              diff_gt_15_16_s;

  // Saturating increment for the settle timer: it parks at all-ones so a rider
  // who has settled long ago still qualifies on the next sample.
  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] val);
    logic [TMR_W-1:0] res;
    if (&val) begin
      res = val;
    end else begin
      res = val + TMR_ONE;
    end
    return res;
  endfunction

  // Load-cell arithmetic: total weight, side-to-side imbalance and the
  // weight-relative imbalance limits.
  always_comb begin
    sum_s       = {1'b0, lft_ld} + {1'b0, rght_ld};
    if (lft_ld >= rght_ld) begin
      diff_s = lft_ld - rght_ld;
    end else begin
      diff_s = rght_ld - lft_ld;
    end
    sum_q_s         = sum_s >> 2;
    sum_15_16_s     = sum_s - (sum_s >> 4);
    sum_gt_min_s    = (sum_s > ON_THR);
    sum_lt_min_s    = (sum_s < OFF_THR);
    diff_gt_1_4_s   = ({1'b0, diff_s} > sum_q_s);
    diff_gt_15_16_s = ({1'b0, diff_s} > sum_15_16_s);
  end

  assign tmr_full_s = &tmr_r;

  // Next-state decode: loss of power wins over everything; every other move
  // is taken only on a valid sample.
  always_comb begin
    state_nxt_s = state_r;
    tmr_clr_s   = 1'b0;
    if (!pwr_up) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (vld && sum_gt_min_s) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (vld) begin
            if (sum_lt_min_s) begin
              state_nxt_s = ST_IDLE;
            end else if (diff_gt_1_4_s) begin
              // Leaning rider restarts the settle period, even if the timer
              // had already filled.
              state_nxt_s = ST_WAIT;
              tmr_clr_s   = 1'b1;
            end else if (tmr_full_s) begin
              state_nxt_s = ST_STEER;
            end else begin
              state_nxt_s = ST_WAIT;
            end
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_STEER: begin
          if (vld) begin
            if (sum_lt_min_s) begin
              state_nxt_s = ST_IDLE;
            end else if (diff_gt_15_16_s) begin
              state_nxt_s = ST_WAIT;
            end else begin
              state_nxt_s = ST_STEER;
            end
          end else begin
            state_nxt_s = ST_STEER;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Settle-timer next value: zero outside WAIT and on each fresh entry into
  // WAIT, so the full count is always measured from a clean start.
  always_comb begin
    if (state_nxt_s != ST_WAIT) begin
      tmr_nxt_s = TMR_ZERO;
    end else if ((state_r != ST_WAIT) || tmr_clr_s) begin
      tmr_nxt_s = TMR_ZERO;
    end else begin
      tmr_nxt_s = sat_inc(tmr_r);
    end
  end

  // State, timer and output flops. Outputs are registered from the next-state
  // decode so they always line up with the state flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      tmr_r       <= TMR_ZERO;
      en_steer_r  <= 1'b0;
      rider_off_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      tmr_r       <= tmr_nxt_s;
      en_steer_r  <= (state_nxt_s == ST_STEER);
      rider_off_r <= (state_nxt_s == ST_IDLE);
    end
  end

  assign en_steer  = en_steer_r;
  assign rider_off = rider_off_r;
  assign seq_state = state_r;

endmodule

// File: tb/tb_rider_steer_seq.sv
// -----------------------------------------------------------------------------
// tb_rider_steer_seq
//
// Self-checking bench for rider_steer_seq (fast_sim=1). A behavioural model
// tracks the rider state and the number of clocks the rider has been settled,
// computed straight from the weight/imbalance rules with integer arithmetic.
// Every clock the DUT outputs are compared against the model.
// -----------------------------------------------------------------------------
module tb_rider_steer_seq;

  localparam int ON_THR   = 'h240;
  localparam int OFF_THR  = 'h1C0;
  localparam int SETTLE   = 32767;   // clocks in WAIT before steering allowed

  localparam int M_IDLE   = 0;
  localparam int M_WAIT   = 1;
  localparam int M_STEER  = 2;

  logic        clk;
  logic        rst;
  logic        vld;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        pwr_up;
  logic        en_steer;
  logic        rider_off;
  logic [1:0]  seq_state;

  int test_cnt;
  int fail_cnt;

  // Reference model
  int m_state;
  int m_settled;

  rider_steer_seq #(
    .fast_sim    (1'b1),
    .MIN_RIDER_WT(12'h200),
    .WT_HYST     (8'h40)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vld      (vld),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .pwr_up   (pwr_up),
    .en_steer (en_steer),
    .rider_off(rider_off),
    .seq_state(seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_state   = M_IDLE;
    m_settled = 0;
  endtask

  // One clock of rider behaviour, from the sampled inputs.
  task automatic model_step();
    int s;
    int d;
    int nxt;
    bit restart;
    if (rst) begin
      model_reset();
      return;
    end
    s       = int'(lft_ld) + int'(rght_ld);
    d       = (lft_ld > rght_ld) ? int'(lft_ld) - int'(rght_ld) : int'(rght_ld) - int'(lft_ld);
    nxt     = m_state;
    restart = 1'b0;
    if (!pwr_up) begin
      nxt = M_IDLE;
    end else if (vld) begin
      if (m_state == M_IDLE) begin
        if (s > ON_THR) nxt = M_WAIT;
      end else if (m_state == M_WAIT) begin
        if (s < OFF_THR) nxt = M_IDLE;
        else if (d > s / 4) restart = 1'b1;
        else if (m_settled >= SETTLE) nxt = M_STEER;
      end else begin
        if (s < OFF_THR) nxt = M_IDLE;
        else if (d > s - s / 16) nxt = M_WAIT;
      end
    end
    if (nxt != M_WAIT || m_state != M_WAIT || restart) m_settled = 0;
    else if (m_settled < SETTLE) m_settled = m_settled + 1;
    m_state = nxt;
  endtask

  task automatic check_all(input string tag);
    logic [1:0] exp_state;
    logic       exp_en;
    logic       exp_off;
    exp_state = 2'(m_state);
    exp_en    = (m_state == M_STEER);
    exp_off   = (m_state == M_IDLE);
    test_cnt++;
    assert (seq_state === exp_state) else begin
      fail_cnt++;
      $error("FAIL %s seq_state got %b exp %b", tag, seq_state, exp_state);
    end
    test_cnt++;
    assert (en_steer === exp_en) else begin
      fail_cnt++;
      $error("FAIL %s en_steer got %b exp %b", tag, en_steer, exp_en);
    end
    test_cnt++;
    assert (rider_off === exp_off) else begin
      fail_cnt++;
      $error("FAIL %s rider_off got %b exp %b", tag, rider_off, exp_off);
    end
  endtask

  // Advance one clock, update the model, compare just after the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // n clocks with a vld strobe every 'per' clocks.
  task automatic run(input int n, input int per, input string tag);
    for (int i = 0; i < n; i++) begin
      vld = ((i % per) == (per - 1));
      tick(tag);
    end
    vld = 1'b0;
  endtask

  task automatic set_ld(input logic [11:0] l, input logic [11:0] r);
    lft_ld  = l;
    rght_ld = r;
  endtask

  initial begin
    test_cnt = 0;
    fail_cnt = 0;
    rst      = 1'b0;
    vld      = 1'b0;
    pwr_up   = 1'b0;
    lft_ld   = 12'h000;
    rght_ld  = 12'h000;
    model_reset();

    // Reset values, applied before any clock edge.
    #1 rst = 1'b1;
    #1 check_all("reset");
    tick("reset_hold");
    tick("reset_hold");
    rst    = 1'b0;
    pwr_up = 1'b1;

    // Sum exactly at on_thr: no entry to WAIT.
    set_ld(12'h120, 12'h120);
    run(64, 16, "idle_at_on_thr");
    test_cnt++;
    assert (seq_state === 2'b00) else begin
      fail_cnt++;
      $error("FAIL idle_at_on_thr_state got %b exp %b", seq_state, 2'b00);
    end

    // One count above on_thr enters WAIT.
    set_ld(12'h121, 12'h120);
    run(32, 16, "enter_wait");

    // Sum exactly at off_thr in WAIT: stays.
    set_ld(12'h0E0, 12'h0E0);
    run(48, 16, "wait_at_off_thr");
    test_cnt++;
    assert (seq_state === 2'b01) else begin
      fail_cnt++;
      $error("FAIL wait_at_off_thr_state got %b exp %b", seq_state, 2'b01);
    end

    // Below off_thr: back to IDLE.
    set_ld(12'h0D0, 12'h0D0);
    run(32, 16, "wait_to_idle");

    // Power drop in WAIT with no vld -> IDLE next clock.
    set_ld(12'h150, 12'h150);
    run(40, 16, "rewait");
    pwr_up = 1'b0;
    vld    = 1'b0;
    tick("pwr_drop");
    pwr_up = 1'b1;
    run(40, 16, "pwr_back");

    // Randomised loads near the thresholds, random vld and rare power drops.
    for (int i = 0; i < 1500; i++) begin
      set_ld(12'($urandom_range(32'h0B0, 32'h170)), 12'($urandom_range(32'h0B0, 32'h170)));
      if ($urandom_range(0, 7) == 0) begin
        set_ld(12'($urandom_range(32'h000, 32'h300)), 12'($urandom_range(32'h000, 32'h080)));
      end
      vld    = ($urandom_range(0, 5) == 0);
      pwr_up = ($urandom_range(0, 99) != 0);
      tick("random");
    end
    vld    = 1'b0;
    pwr_up = 1'b1;

    // Balanced rider settles into STEER.
    set_ld(12'h150, 12'h150);
    run(33000, 16, "settle");
    test_cnt++;
    assert (en_steer === 1'b1) else begin
      fail_cnt++;
      $error("FAIL steer_reached got %b exp %b", en_steer, 1'b1);
    end

    // Light but balanced rider above off_thr keeps steering.
    set_ld(12'h100, 12'h100);
    run(64, 16, "steer_light");

    // Rider leaning off one side: back to WAIT.
    set_ld(12'h2A0, 12'h000);
    run(16, 16, "lean_off");
    test_cnt++;
    assert (seq_state === 2'b01) else begin
      fail_cnt++;
      $error("FAIL lean_off_state got %b exp %b", seq_state, 2'b01);
    end

    // Imbalanced rider keeps restarting the settle time, then balances.
    set_ld(12'h200, 12'h080);
    run(3000, 16, "imbalanced");
    set_ld(12'h150, 12'h150);
    run(33000, 16, "resettle");

    // Asynchronous reset mid-STEER, observed before the next clock edge.
    run(8, 16, "pre_rst");
    #3 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    tick("rst_hold");
    rst = 1'b0;
    set_ld(12'h120, 12'h120);
    run(32, 16, "post_rst");

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
